bpu_rs1_arb: RTL and testbench

BPU_RS1_ARB -- requirements
Module: bpu_rs1_arb

---
 rtl/bpu_rs1_arb_pkg.sv | 45 ++++
 rtl/bpu_rs1_arb_if.sv | 36 +++
 rtl/bpu_rs1_arb.sv | 73 +++++++
 tb/tb_bpu_rs1_arb.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/bpu_rs1_arb_pkg.sv
// Shared widths, FSM encodings and payload types for the BPU/EXU rs1 regfile read-port arbiter.
package bpu_rs1_arb_pkg;

    localparam int unsigned XLEN        = 32;
    localparam int unsigned RFIDX_WIDTH = 5;
    localparam int unsigned CNT_W       = 4;

    // Outstanding-read tracker; encodings are fixed so they line up with the core's defines.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RD_BPU = 2'd1,
        ST_RD_EXU = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic                   valid;
        logic [XLEN-1:0]        data;
    } rd_rsp_t;

    // Index steered onto the shared port: the granted requester's index, else 0.
    function automatic logic [RFIDX_WIDTH-1:0] sel_idx(
        input logic                   bpu_gnt,
        input logic [RFIDX_WIDTH-1:0] bpu_idx,
        input logic                   exu_gnt,
        input logic [RFIDX_WIDTH-1:0] exu_idx
    );
        logic [RFIDX_WIDTH-1:0] idx;
        idx = '0;
        if (bpu_gnt) begin
            idx = bpu_idx;
        end else if (exu_gnt) begin
            idx = exu_idx;
        end
        return idx;
    endfunction

    // Response payload: data is forced to 0 whenever the response is not valid.
    function automatic rd_rsp_t make_rsp(input logic valid, input logic [XLEN-1:0] data);
        rd_rsp_t rsp;
        rsp.valid = valid;
        rsp.data  = valid ? data : '0;
        return rsp;
    endfunction

endpackage

// File: rtl/bpu_rs1_arb_if.sv
// Request/grant/response bundle between the BPU, the EXU, regfile read port 1 and the arbiter.
interface bpu_rs1_arb_if;
    import bpu_rs1_arb_pkg::*;

    logic                   bpu_req;
    logic [RFIDX_WIDTH-1:0] bpu_rs1idx;
    logic                   bpu_gnt;
    logic                   bpu_rvalid;
    logic [XLEN-1:0]        bpu_rdata;

    logic                   exu_req;
    logic [RFIDX_WIDTH-1:0] exu_rs1idx;
    logic                   exu_gnt;
    logic                   exu_rvalid;
    logic [XLEN-1:0]        exu_rdata;

    logic                   flush;

    logic                   rf_rd_ena;
    logic [RFIDX_WIDTH-1:0] rf_rd_idx;
    logic [XLEN-1:0]        rf_rd_data;

    // Requesters and regfile side.
    modport master (
        output bpu_req, bpu_rs1idx, exu_req, exu_rs1idx, flush, rf_rd_data,
        input  bpu_gnt, bpu_rvalid, bpu_rdata, exu_gnt, exu_rvalid, exu_rdata,
        input  rf_rd_ena, rf_rd_idx
    );

    // Arbiter side.
    modport slave (
        input  bpu_req, bpu_rs1idx, exu_req, exu_rs1idx, flush, rf_rd_data,
        output bpu_gnt, bpu_rvalid, bpu_rdata, exu_gnt, exu_rvalid, exu_rdata,
        output rf_rd_ena, rf_rd_idx
    );
endinterface

// File: rtl/bpu_rs1_arb.sv
// Arbitrates regfile read port 1 between BPU jalr rs1 and EXU rs1 reads, with an optional
// BPU starvation guard compiled in by BPU_ARB_STARVE_EN.
module bpu_rs1_arb
    import bpu_rs1_arb_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 3
) (
    input  logic         clk,
    input  logic         rst,
    bpu_rs1_arb_if.slave arb
);

    if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve_max
        $error("bpu_rs1_arb: STARVE_MAX must be within 1..15");
    end

    arb_state_e r_state;
    logic       w_bpu_gnt;
    logic       w_exu_gnt;
    logic       w_starve_hit;
    rd_rsp_t    w_bpu_rsp;
    rd_rsp_t    w_exu_rsp;

`ifdef BPU_ARB_STARVE_EN
    logic [CNT_W-1:0] r_starve_cnt;
    assign w_starve_hit = (r_starve_cnt == CNT_W'(STARVE_MAX));
`else
    assign w_starve_hit = 1'b0;
`endif

    // EXU wins ties unless the BPU has waited its limit; flush and reset kill BPU grants.
    assign w_bpu_gnt = ~rst & ~arb.flush & arb.bpu_req & (~arb.exu_req | w_starve_hit);
    assign w_exu_gnt = ~rst & arb.exu_req & ~w_bpu_gnt;

    assign arb.bpu_gnt   = w_bpu_gnt;
    assign arb.exu_gnt   = w_exu_gnt;
    assign arb.rf_rd_ena = w_bpu_gnt | w_exu_gnt;
    assign arb.rf_rd_idx = sel_idx(w_bpu_gnt, arb.bpu_rs1idx, w_exu_gnt, arb.exu_rs1idx);

    // Read data arrives the cycle after the grant; a flush that lands on it drops the BPU response.
    assign w_bpu_rsp = make_rsp(~rst & ~arb.flush & (r_state == ST_RD_BPU), arb.rf_rd_data);
    assign w_exu_rsp = make_rsp(~rst & (r_state == ST_RD_EXU), arb.rf_rd_data);

    assign arb.bpu_rvalid = w_bpu_rsp.valid;
    assign arb.bpu_rdata  = w_bpu_rsp.data;
    assign arb.exu_rvalid = w_exu_rsp.valid;
    assign arb.exu_rdata  = w_exu_rsp.data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
`ifdef BPU_ARB_STARVE_EN
            r_starve_cnt <= '0;
`endif
        end else begin
            if (w_bpu_gnt) begin
                r_state <= ST_RD_BPU;
            end else if (w_exu_gnt) begin
                r_state <= ST_RD_EXU;
            end else begin
                r_state <= ST_IDLE;
            end
`ifdef BPU_ARB_STARVE_EN
            if (arb.flush || !arb.bpu_req || w_bpu_gnt) begin
                r_starve_cnt <= '0;
            end else if (!w_starve_hit) begin
                r_starve_cnt <= r_starve_cnt + CNT_W'(1);
            end
`endif
        end
    end

endmodule

// File: tb/tb_bpu_rs1_arb.sv
// Directed bench for bpu_rs1_arb; checks follow BPU_ARB_STARVE_EN when it is defined.
module tb_bpu_rs1_arb;
    import bpu_rs1_arb_pkg::*;

    logic clk;
    logic rst;
    int   errs;
    int   checks;

    bpu_rs1_arb_if ifc ();

    bpu_rs1_arb #(.STARVE_MAX(3)) dut (
        .clk (clk),
        .rst (rst),
        .arb (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Regfile model: synchronous read, x0 reads 0, garbage when not enabled.
    function automatic logic [XLEN-1:0] rf_val(input logic [RFIDX_WIDTH-1:0] idx);
        return (idx == '0) ? '0 : (32'h8000_0000 | (XLEN'(idx) << 4));
    endfunction

    always @(posedge clk) begin
        ifc.rf_rd_data <= ifc.rf_rd_ena ? rf_val(ifc.rf_rd_idx) : 32'hDEAD_BEEF;
    end

    // Apply one cycle of stimulus after the falling edge, then let combinational outputs settle.
    task automatic drive(input logic br, input logic [4:0] bi, input logic er,
                         input logic [4:0] ei, input logic fl, input logic r);
        @(negedge clk);
        ifc.bpu_req    = br;
        ifc.bpu_rs1idx = bi;
        ifc.exu_req    = er;
        ifc.exu_rs1idx = ei;
        ifc.flush      = fl;
        rst            = r;
        #1;
    endtask

    task automatic test_reset();
        drive(1'b1, 5'd3, 1'b1, 5'd4, 1'b0, 1'b1);
        drive(1'b1, 5'd3, 1'b1, 5'd4, 1'b0, 1'b1);
        checks++; if (ifc.bpu_gnt !== 1'b0) begin errs++; $display("FAIL reset_bpu_gnt got=%0h exp=0", ifc.bpu_gnt); end
        checks++; if (ifc.exu_gnt !== 1'b0) begin errs++; $display("FAIL reset_exu_gnt got=%0h exp=0", ifc.exu_gnt); end
        checks++; if (ifc.rf_rd_ena !== 1'b0) begin errs++; $display("FAIL reset_rf_rd_ena got=%0h exp=0", ifc.rf_rd_ena); end
        checks++; if (ifc.rf_rd_idx !== 5'd0) begin errs++; $display("FAIL reset_rf_rd_idx got=%0h exp=0", ifc.rf_rd_idx); end
        checks++; if ({ifc.bpu_rvalid, ifc.exu_rvalid} !== 2'b00) begin errs++; $display("FAIL reset_rvalid got=%0b exp=00", {ifc.bpu_rvalid, ifc.exu_rvalid}); end
        checks++; if ({ifc.bpu_rdata, ifc.exu_rdata} !== 64'd0) begin errs++; $display("FAIL reset_rdata got=%0h exp=0", {ifc.bpu_rdata, ifc.exu_rdata}); end
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        checks++; if ({ifc.bpu_rvalid, ifc.exu_rvalid} !== 2'b00) begin errs++; $display("FAIL reset_release_rvalid got=%0b exp=00", {ifc.bpu_rvalid, ifc.exu_rvalid}); end
    endtask

    task automatic test_bpu_single();
        drive(1'b1, 5'd1, 1'b0, 5'd0, 1'b0, 1'b0);
        checks++; if (ifc.bpu_gnt !== 1'b1) begin errs++; $display("FAIL single_bpu_gnt got=%0h exp=1", ifc.bpu_gnt); end
        checks++; if (ifc.exu_gnt !== 1'b0) begin errs++; $display("FAIL single_exu_gnt got=%0h exp=0", ifc.exu_gnt); end
        checks++; if ({ifc.rf_rd_ena, ifc.rf_rd_idx} !== 6'b1_00001) begin errs++; $display("FAIL single_rf_port got=%0h exp=21", {ifc.rf_rd_ena, ifc.rf_rd_idx}); end
        checks++; if (ifc.bpu_rvalid !== 1'b0) begin errs++; $display("FAIL single_early_rvalid got=%0h exp=0", ifc.bpu_rvalid); end
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        checks++; if (ifc.bpu_rvalid !== 1'b1) begin errs++; $display("FAIL single_rvalid got=%0h exp=1", ifc.bpu_rvalid); end
        checks++; if (ifc.bpu_rdata !== 32'h8000_0010) begin errs++; $display("FAIL single_rdata got=%0h exp=80000010", ifc.bpu_rdata); end
        checks++; if ({ifc.exu_rvalid, ifc.exu_rdata} !== 33'd0) begin errs++; $display("FAIL single_exu_quiet got=%0h exp=0", {ifc.exu_rvalid, ifc.exu_rdata}); end
        checks++; if ({ifc.rf_rd_ena, ifc.rf_rd_idx} !== 6'd0) begin errs++; $display("FAIL single_rf_idle got=%0h exp=0", {ifc.rf_rd_ena, ifc.rf_rd_idx}); end
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        checks++; if ({ifc.bpu_rvalid, ifc.bpu_rdata} !== 33'd0) begin errs++; $display("FAIL single_rvalid_one_cycle got=%0h exp=0", {ifc.bpu_rvalid, ifc.bpu_rdata}); end
    endtask

    task automatic test_priority();
        logic [1:0] exp_gnt [5];   // {bpu_gnt, exu_gnt} per cycle
`ifdef BPU_ARB_STARVE_EN
        exp_gnt = '{2'b01, 2'b01, 2'b01, 2'b10, 2'b01};
`else
        exp_gnt = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b01};
`endif
        for (int c = 0; c < 5; c++) begin
            drive(1'b1, 5'd3, 1'b1, 5'd4, 1'b0, 1'b0);
            checks++;
            if ({ifc.bpu_gnt, ifc.exu_gnt} !== exp_gnt[c]) begin
                errs++; $display("FAIL prio_gnt_c%0d got=%02b exp=%02b", c, {ifc.bpu_gnt, ifc.exu_gnt}, exp_gnt[c]);
            end
            checks++;
            if (ifc.rf_rd_idx !== (exp_gnt[c][1] ? 5'd3 : 5'd4)) begin
                errs++; $display("FAIL prio_idx_c%0d got=%0d exp=%0d", c, ifc.rf_rd_idx, exp_gnt[c][1] ? 5'd3 : 5'd4);
            end
        end
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        checks++; if ({ifc.exu_rvalid, ifc.exu_rdata} !== {1'b1, 32'h8000_0040}) begin errs++; $display("FAIL prio_last_rsp got=%0h exp=180000040", {ifc.exu_rvalid, ifc.exu_rdata}); end
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic test_flush();
        drive(1'b1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0);
        checks++; if (ifc.bpu_gnt !== 1'b1) begin errs++; $display("FAIL flush_pre_gnt got=%0h exp=1", ifc.bpu_gnt); end
        drive(1'b1, 5'd2, 1'b0, 5'd0, 1'b1, 1'b0);
        checks++; if (ifc.bpu_gnt !== 1'b0) begin errs++; $display("FAIL flush_gnt got=%0h exp=0", ifc.bpu_gnt); end
        checks++; if ({ifc.bpu_rvalid, ifc.bpu_rdata} !== 33'd0) begin errs++; $display("FAIL flush_rsp got=%0h exp=0", {ifc.bpu_rvalid, ifc.bpu_rdata}); end
        checks++; if (ifc.rf_rd_ena !== 1'b0) begin errs++; $display("FAIL flush_rf_ena got=%0h exp=0", ifc.rf_rd_ena); end
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        checks++; if ({ifc.bpu_rvalid, ifc.exu_rvalid} !== 2'b00) begin errs++; $display("FAIL flush_idle got=%0b exp=00", {ifc.bpu_rvalid, ifc.exu_rvalid}); end
`ifdef BPU_ARB_STARVE_EN
        // Build up two denied cycles, flush, then the full limit must elapse again.
        drive(1'b1, 5'd3, 1'b1, 5'd4, 1'b0, 1'b0);
        drive(1'b1, 5'd3, 1'b1, 5'd4, 1'b0, 1'b0);
        drive(1'b1, 5'd3, 1'b1, 5'd4, 1'b1, 1'b0);
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, 5'd3, 1'b1, 5'd4, 1'b0, 1'b0);
            checks++; if (ifc.exu_gnt !== 1'b1) begin errs++; $display("FAIL flush_cnt_clear_c%0d got=%0h exp=1", c, ifc.exu_gnt); end
        end
        drive(1'b1, 5'd3, 1'b1, 5'd4, 1'b0, 1'b0);
        checks++; if (ifc.bpu_gnt !== 1'b1) begin errs++; $display("FAIL flush_cnt_force got=%0h exp=1", ifc.bpu_gnt); end
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
`endif
    endtask

    task automatic test_exu_flush();
        drive(1'b0, 5'd0, 1'b1, 5'd8, 1'b1, 1'b0);
        checks++; if ({ifc.exu_gnt, ifc.rf_rd_idx} !== 6'b1_01000) begin errs++; $display("FAIL exu_flush_gnt got=%0h exp=28", {ifc.exu_gnt, ifc.rf_rd_idx}); end
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);
        checks++; if ({ifc.exu_rvalid, ifc.exu_rdata} !== {1'b1, 32'h8000_0080}) begin errs++; $display("FAIL exu_flush_rsp got=%0h exp=180000080", {ifc.exu_rvalid, ifc.exu_rdata}); end
    endtask

    task automatic test_back_to_back();
        // {bpu_req, exu_req, idx} per cycle; last row is an idle cycle to drain.
        logic [6:0]  stim     [5];
        logic [33:0] exp_rsp  [5];  // {bpu_rvalid, exu_rvalid, rdata of the valid side}
        stim    = '{{2'b01, 5'd5}, {2'b10, 5'd6}, {2'b01, 5'd0}, {2'b10, 5'd7}, {2'b00, 5'd0}};
        exp_rsp = '{{2'b00, 32'h0}, {2'b01, 32'h8000_0050}, {2'b10, 32'h8000_0060},
                    {2'b01, 32'h0}, {2'b10, 32'h8000_0070}};
        for (int c = 0; c < 5; c++) begin
            drive(stim[c][6], stim[c][4:0], stim[c][5], stim[c][4:0], 1'b0, 1'b0);
            checks++;
            if ({ifc.bpu_gnt, ifc.exu_gnt} !== stim[c][6:5]) begin
                errs++; $display("FAIL b2b_gnt_c%0d got=%02b exp=%02b", c, {ifc.bpu_gnt, ifc.exu_gnt}, stim[c][6:5]);
            end
            checks++;
            if ({ifc.bpu_rvalid, ifc.exu_rvalid, ifc.bpu_rdata | ifc.exu_rdata} !== exp_rsp[c]) begin
                errs++; $display("FAIL b2b_rsp_c%0d got=%0h exp=%0h", c, {ifc.bpu_rvalid, ifc.exu_rvalid, ifc.bpu_rdata | ifc.exu_rdata}, exp_rsp[c]);
            end
        end
    endtask

    task automatic test_reset_mid();
        drive(1'b0, 5'd0, 1'b1, 5'd9, 1'b0, 1'b0);
        checks++; if (ifc.exu_gnt !== 1'b1) begin errs++; $display("FAIL rstmid_gnt got=%0h exp=1", ifc.exu_gnt); end
        drive(1'b1, 5'd1, 1'b1, 5'd9, 1'b0, 1'b1);
        checks++;
        if ({ifc.bpu_gnt, ifc.exu_gnt, ifc.rf_rd_ena, ifc.rf_rd_idx, ifc.bpu_rvalid, ifc.exu_rvalid} !== 10'd0) begin
            errs++; $display("FAIL rstmid_ctrl got=%0h exp=0", {ifc.bpu_gnt, ifc.exu_gnt, ifc.rf_rd_ena, ifc.rf_rd_idx, ifc.bpu_rvalid, ifc.exu_rvalid});
        end
        checks++; if ({ifc.bpu_rdata, ifc.exu_rdata} !== 64'd0) begin errs++; $display("FAIL rstmid_rdata got=%0h exp=0", {ifc.bpu_rdata, ifc.exu_rdata}); end
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        checks++; if ({ifc.bpu_rvalid, ifc.exu_rvalid} !== 2'b00) begin errs++; $display("FAIL rstmid_release got=%0b exp=00", {ifc.bpu_rvalid, ifc.exu_rvalid}); end
    endtask

    initial begin
        errs           = 0;
        checks         = 0;
        rst            = 1'b1;
        ifc.bpu_req    = 1'b0;
        ifc.bpu_rs1idx = '0;
        ifc.exu_req    = 1'b0;
        ifc.exu_rs1idx = '0;
        ifc.flush      = 1'b0;
        test_reset();
        test_bpu_single();
        test_priority();
        test_flush();
        test_exu_flush();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
